divisor_secuencial: RTL and testbench

- Parametrised iterative restoring divider, one quotient bit per clock. Successor to the fixed 16-bit quotient-only divider.
- Adds generic operand width, remainder output, signed/unsigned mode per operation, a busy flag, divide-by-zero detection and signed overflow detection.
- Sits behind the calculator control FSM, which launches one operation at a time and waits for terminado.

---
 rtl/divisor_pkg.sv | 18 +
 rtl/divisor_paso.sv | 23 ++
 rtl/divisor_secuencial.sv | 152 +++++++++++++++
 tb/tb_divisor_secuencial.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/divisor_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package divisor_pkg;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        CALCULO = 2'd1,
        AJUSTE  = 2'd2,
        FIN     = 2'd3
    } estado_div_t;

    localparam int ANCHO_DEF = 16;

    // Bits needed for a down-counter that is loaded with the operand width.
    function automatic int ancho_cnt(input int ancho);
        return $clog2(ancho + 1);
    endfunction

endpackage

// File: rtl/divisor_paso.sv
// One restoring-division step: shift in a dividend bit and trial-subtract the divisor.
module divisor_paso #(
    parameter int ANCHO = 16
) (
    input  logic [ANCHO-1:0] rem_in,
    input  logic             bit_in,
    input  logic [ANCHO-1:0] div_mag,
    output logic [ANCHO-1:0] rem_out,
    output logic             q_bit
);

    logic [ANCHO:0] desplazado;
    logic [ANCHO:0] resta;

    assign desplazado = {rem_in, bit_in};
    assign resta      = desplazado - {1'b0, div_mag};

    // rem_in < div_mag always holds, so a set top bit of the shifted value
    // already guarantees the trial subtraction cannot go negative.
    assign q_bit   = desplazado[ANCHO] | ~resta[ANCHO];
    assign rem_out = q_bit ? resta[ANCHO-1:0] : desplazado[ANCHO-1:0];

endmodule

// File: rtl/divisor_secuencial.sv
// Iterative signed/unsigned restoring divider, one quotient bit per clock.
//   state   | meaning
//   REPOSO  | idle, waits for iniciar and latches operands
//   CALCULO | ANCHO restoring steps, counter runs down to terminal count
//   AJUSTE  | sign correction and result registration
//   FIN     | terminado pulse, results valid
module divisor_secuencial
    import divisor_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iniciar,
    input  logic             con_signo,
    input  logic [ANCHO-1:0] dividendo,
    input  logic [ANCHO-1:0] divisor,
    output logic [ANCHO-1:0] cociente,
    output logic [ANCHO-1:0] residuo,
    output logic             div_cero,
    output logic             desbordamiento,
    output logic             ocupado,
    output logic             terminado
);

    localparam int CW = ancho_cnt(ANCHO);

    estado_div_t      estado_q, estado_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [ANCHO-1:0] rem_q, rem_d;
    logic [ANCHO-1:0] dq_q, dq_d;
    logic [ANCHO-1:0] mag_q, mag_d;
    logic             signo_q, signo_d;
    logic             sgn_coc_q, sgn_coc_d;
    logic             sgn_res_q, sgn_res_d;
    logic [ANCHO-1:0] coc_q, coc_d;
    logic [ANCHO-1:0] res_q, res_d;
    logic             dz_q, dz_d;
    logic             ov_q, ov_d;

    logic             neg_a, neg_b;
    logic [ANCHO-1:0] paso_rem;
    logic             paso_q;

    assign neg_a = con_signo & dividendo[ANCHO-1];
    assign neg_b = con_signo & divisor[ANCHO-1];

    // dq_q starts as the dividend magnitude and fills with quotient bits from the LSB.
    divisor_paso #(.ANCHO(ANCHO)) u_paso (
        .rem_in  (rem_q),
        .bit_in  (dq_q[ANCHO-1]),
        .div_mag (mag_q),
        .rem_out (paso_rem),
        .q_bit   (paso_q)
    );

    always_comb begin
        estado_d  = estado_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dq_d      = dq_q;
        mag_d     = mag_q;
        signo_d   = signo_q;
        sgn_coc_d = sgn_coc_q;
        sgn_res_d = sgn_res_q;
        coc_d     = coc_q;
        res_d     = res_q;
        dz_d      = dz_q;
        ov_d      = ov_q;
        case (estado_q)
            REPOSO: begin
                if (iniciar) begin
                    signo_d   = con_signo;
                    dq_d      = neg_a ? -dividendo : dividendo;
                    mag_d     = neg_b ? -divisor : divisor;
                    sgn_coc_d = neg_a ^ neg_b;
                    sgn_res_d = neg_a;
                    rem_d     = '0;
                    ov_d      = con_signo && (dividendo == {1'b1, {(ANCHO-1){1'b0}}})
                                && (divisor == {ANCHO{1'b1}});
                    if (divisor == '0) begin
                        dz_d     = 1'b1;
                        coc_d    = {ANCHO{1'b1}};
                        res_d    = dividendo;
                        estado_d = FIN;
                    end else begin
                        dz_d     = 1'b0;
                        cnt_d    = CW'(ANCHO);
                        estado_d = CALCULO;
                    end
                end
            end
            CALCULO: begin
                rem_d = paso_rem;
                dq_d  = {dq_q[ANCHO-2:0], paso_q};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    estado_d = AJUSTE;
                end
            end
            AJUSTE: begin
                coc_d    = (signo_q & sgn_coc_q) ? -dq_q : dq_q;
                res_d    = (signo_q & sgn_res_q) ? -rem_q : rem_q;
                estado_d = FIN;
            end
            FIN: begin
                estado_d = REPOSO;
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q  <= REPOSO;
            cnt_q     <= '0;
            rem_q     <= '0;
            dq_q      <= '0;
            mag_q     <= '0;
            signo_q   <= 1'b0;
            sgn_coc_q <= 1'b0;
            sgn_res_q <= 1'b0;
            coc_q     <= '0;
            res_q     <= '0;
            dz_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dq_q      <= dq_d;
            mag_q     <= mag_d;
            signo_q   <= signo_d;
            sgn_coc_q <= sgn_coc_d;
            sgn_res_q <= sgn_res_d;
            coc_q     <= coc_d;
            res_q     <= res_d;
            dz_q      <= dz_d;
            ov_q      <= ov_d;
        end
    end

    assign cociente       = coc_q;
    assign residuo        = res_q;
    assign div_cero       = dz_q;
    assign desbordamiento = ov_q;
    assign ocupado        = (estado_q != REPOSO);
    assign terminado      = (estado_q == FIN);

endmodule

// File: tb/tb_divisor_secuencial.sv
// Directed bench for divisor_secuencial at ANCHO=16 and ANCHO=8.
module tb_divisor_secuencial;

    logic        clk = 1'b0;
    logic        rst;
    logic        iniciar, con_signo;
    logic [15:0] dividendo, divisor, cociente, residuo;
    logic        div_cero, desbordamiento, ocupado, terminado;

    logic        iniciar8, con_signo8;
    logic [7:0]  dividendo8, divisor8, cociente8, residuo8;
    logic        div_cero8, desbordamiento8, ocupado8, terminado8;

    int errs;
    int chks;

    always #5 clk = ~clk;

    divisor_secuencial #(.ANCHO(16)) u16 (
        .clk(clk), .rst(rst), .iniciar(iniciar), .con_signo(con_signo),
        .dividendo(dividendo), .divisor(divisor), .cociente(cociente),
        .residuo(residuo), .div_cero(div_cero), .desbordamiento(desbordamiento),
        .ocupado(ocupado), .terminado(terminado)
    );

    divisor_secuencial #(.ANCHO(8)) u8 (
        .clk(clk), .rst(rst), .iniciar(iniciar8), .con_signo(con_signo8),
        .dividendo(dividendo8), .divisor(divisor8), .cociente(cociente8),
        .residuo(residuo8), .div_cero(div_cero8), .desbordamiento(desbordamiento8),
        .ocupado(ocupado8), .terminado(terminado8)
    );

    // Launch one 16-bit operation; returns edges from acceptance to terminado.
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output int edges, output bit busy_all);
        @(negedge clk);
        dividendo = a; divisor = b; con_signo = s; iniciar = 1'b1;
        @(posedge clk);
        edges = 1; busy_all = 1'b1;
        @(negedge clk);
        iniciar = 1'b0;
        while (!terminado && edges < 100) begin
            if (!ocupado) busy_all = 1'b0;
            @(posedge clk); edges++;
            @(negedge clk);
        end
        if (!ocupado) busy_all = 1'b0;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output int edges);
        @(negedge clk);
        dividendo8 = a; divisor8 = b; con_signo8 = s; iniciar8 = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        iniciar8 = 1'b0;
        while (!terminado8 && edges < 100) begin
            @(posedge clk); edges++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #1;
        chks++;
        if ({cociente, residuo, div_cero, desbordamiento, ocupado, terminado} !== 36'd0) begin
            errs++; $display("FAIL reset16: got coc=%h res=%h dz=%b ov=%b oc=%b t=%b want all 0",
                             cociente, residuo, div_cero, desbordamiento, ocupado, terminado);
        end
        chks++;
        if ({cociente8, residuo8, div_cero8, desbordamiento8, ocupado8, terminado8} !== 20'd0) begin
            errs++; $display("FAIL reset8: got coc=%h res=%h oc=%b t=%b want all 0",
                             cociente8, residuo8, ocupado8, terminado8);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unsigned;
        int e; bit b;
        run16(16'd42, 16'd3, 1'b0, e, b);
        chks++; if (terminado !== 1'b1) begin errs++; $display("FAIL u42_3 term: got %b want 1", terminado); end
        chks++; if (e != 18) begin errs++; $display("FAIL u42_3 latency: got %0d want 18", e); end
        chks++; if (b !== 1'b1) begin errs++; $display("FAIL u42_3 ocupado: got dropout want high throughout"); end
        chks++; if (cociente !== 16'd14) begin errs++; $display("FAIL u42_3 coc: got %h want %h", cociente, 16'd14); end
        chks++; if (residuo !== 16'd0) begin errs++; $display("FAIL u42_3 res: got %h want 0", residuo); end
        chks++; if (div_cero !== 1'b0) begin errs++; $display("FAIL u42_3 dz: got %b want 0", div_cero); end
        @(negedge clk);
        chks++; if (terminado !== 1'b0 || ocupado !== 1'b0) begin
            errs++; $display("FAIL pulse: got t=%b oc=%b want 0 0", terminado, ocupado); end
        run16(16'hFFFF, 16'h0100, 1'b0, e, b);
        chks++; if (cociente !== 16'h00FF || residuo !== 16'h00FF) begin
            errs++; $display("FAIL u65535_256: got %h r %h want 00ff r 00ff", cociente, residuo); end
    endtask

    task automatic test_signed;
        int e; bit b;
        run16(16'hFFF9, 16'h0002, 1'b1, e, b);
        chks++; if (cociente !== 16'hFFFD || residuo !== 16'hFFFF) begin
            errs++; $display("FAIL s-7_2: got %h r %h want fffd r ffff", cociente, residuo); end
        chks++; if (e != 18) begin errs++; $display("FAIL s-7_2 latency: got %0d want 18", e); end
        run16(16'h0007, 16'hFFFE, 1'b1, e, b);
        chks++; if (cociente !== 16'hFFFD || residuo !== 16'h0001) begin
            errs++; $display("FAIL s7_-2: got %h r %h want fffd r 0001", cociente, residuo); end
        chks++; if (desbordamiento !== 1'b0) begin errs++; $display("FAIL s7_-2 ov: got %b want 0", desbordamiento); end
    endtask

    task automatic test_div_cero;
        int e; bit b;
        run16(16'd5, 16'd0, 1'b0, e, b);
        chks++; if (e != 1) begin errs++; $display("FAIL dz_u latency: got %0d want 1", e); end
        chks++; if (cociente !== 16'hFFFF || residuo !== 16'd5 || div_cero !== 1'b1) begin
            errs++; $display("FAIL dz_u: got %h r %h dz=%b want ffff r 0005 dz=1", cociente, residuo, div_cero); end
        run16(16'd5, 16'd0, 1'b1, e, b);
        chks++; if (e != 1) begin errs++; $display("FAIL dz_s latency: got %0d want 1", e); end
        chks++; if (cociente !== 16'hFFFF || residuo !== 16'd5 || div_cero !== 1'b1) begin
            errs++; $display("FAIL dz_s: got %h r %h dz=%b want ffff r 0005 dz=1", cociente, residuo, div_cero); end
        run16(16'd42, 16'd3, 1'b0, e, b);
        chks++; if (div_cero !== 1'b0 || cociente !== 16'd14) begin
            errs++; $display("FAIL dz_clear: got dz=%b coc=%h want dz=0 coc=000e", div_cero, cociente); end
    endtask

    task automatic test_overflow;
        int e; bit b;
        run16(16'h8000, 16'hFFFF, 1'b1, e, b);
        chks++; if (cociente !== 16'h8000 || residuo !== 16'h0000) begin
            errs++; $display("FAIL ovf: got %h r %h want 8000 r 0000", cociente, residuo); end
        chks++; if (desbordamiento !== 1'b1) begin errs++; $display("FAIL ovf flag: got %b want 1", desbordamiento); end
        chks++; if (e != 18) begin errs++; $display("FAIL ovf latency: got %0d want 18", e); end
    endtask

    task automatic test_ignore_start;
        int e;
        @(negedge clk);
        dividendo = 16'd100; divisor = 16'd7; con_signo = 1'b0; iniciar = 1'b1;
        @(posedge clk);
        e = 1;
        @(negedge clk);
        iniciar = 1'b0;
        while (!terminado && e < 100) begin
            if (e == 4) begin iniciar = 1'b1; dividendo = 16'd9; divisor = 16'd3; end
            if (e == 6) iniciar = 1'b0;
            if (e == 8) begin dividendo = 16'hFFFF; divisor = 16'd1; con_signo = 1'b1; end
            @(posedge clk); e++;
            @(negedge clk);
        end
        chks++; if (e != 18) begin errs++; $display("FAIL ignore latency: got %0d want 18", e); end
        chks++; if (cociente !== 16'd14 || residuo !== 16'd2) begin
            errs++; $display("FAIL ignore: got %h r %h want 000e r 0002", cociente, residuo); end
    endtask

    task automatic test_back_to_back;
        int e; bit b;
        run16(16'd42, 16'd3, 1'b0, e, b);
        // run16 released iniciar; relaunch and hold it through FIN.
        @(negedge clk);
        dividendo = 16'd42; divisor = 16'd3; con_signo = 1'b0; iniciar = 1'b1;
        e = 0;
        while (!terminado && e < 100) begin @(posedge clk); e++; @(negedge clk); end
        chks++; if (cociente !== 16'd14) begin errs++; $display("FAIL b2b first: got %h want 000e", cociente); end
        dividendo = 16'hFFFF; divisor = 16'h0100;
        @(posedge clk); e = 1;
        @(negedge clk);
        while (!terminado && e < 100) begin @(posedge clk); e++; @(negedge clk); end
        iniciar = 1'b0;
        chks++; if (e != 19) begin errs++; $display("FAIL b2b gap: got %0d want 19", e); end
        chks++; if (cociente !== 16'h00FF || residuo !== 16'h00FF) begin
            errs++; $display("FAIL b2b second: got %h r %h want 00ff r 00ff", cociente, residuo); end
    endtask

    task automatic test_async_reset;
        int e; bit b; bit seen;
        @(negedge clk);
        dividendo = 16'd42; divisor = 16'd3; con_signo = 1'b0; iniciar = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iniciar = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chks++; if (ocupado !== 1'b1) begin errs++; $display("FAIL areset pre: got oc=%b want 1", ocupado); end
        rst = 1'b1;
        #1;
        chks++;
        if ({cociente, residuo, div_cero, desbordamiento, ocupado, terminado} !== 36'd0) begin
            errs++; $display("FAIL areset: got coc=%h res=%h oc=%b t=%b want all 0",
                             cociente, residuo, ocupado, terminado);
        end
        seen = 1'b0;
        repeat (3) begin @(negedge clk); if (terminado) seen = 1'b1; end
        rst = 1'b0;
        repeat (25) begin @(negedge clk); if (terminado || ocupado) seen = 1'b1; end
        chks++; if (seen !== 1'b0) begin errs++; $display("FAIL areset discard: got activity want none"); end
        run16(16'd42, 16'd3, 1'b0, e, b);
        chks++; if (cociente !== 16'd14 || residuo !== 16'd0 || e != 18) begin
            errs++; $display("FAIL areset fresh: got %h r %h at %0d want 000e r 0000 at 18", cociente, residuo, e); end
    endtask

    task automatic test_ancho8;
        int e;
        run8(8'd200, 8'd9, 1'b0, e);
        chks++; if (e != 10) begin errs++; $display("FAIL a8 latency: got %0d want 10", e); end
        chks++; if (cociente8 !== 8'd22 || residuo8 !== 8'd2) begin
            errs++; $display("FAIL a8 200_9: got %h r %h want 16 r 02", cociente8, residuo8); end
        run8(8'h80, 8'hFF, 1'b1, e);
        chks++; if (cociente8 !== 8'h80 || residuo8 !== 8'h00 || desbordamiento8 !== 1'b1) begin
            errs++; $display("FAIL a8 ovf: got %h r %h ov=%b want 80 r 00 ov=1", cociente8, residuo8, desbordamiento8); end
    endtask

    initial begin
        errs = 0; chks = 0;
        rst = 1'b1;
        iniciar = 1'b0; con_signo = 1'b0; dividendo = '0; divisor = '0;
        iniciar8 = 1'b0; con_signo8 = 1'b0; dividendo8 = '0; divisor8 = '0;
        test_reset;
        test_unsigned;
        test_signed;
        test_div_cero;
        test_overflow;
        test_ignore_start;
        test_back_to_back;
        test_async_reset;
        test_ancho8;
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
